// File: rtl/morse_symbol_collector.sv
// morse_symbol_collector
//   Times debounced Morse key presses in timebase ticks, classifies each press
//   as a dot or a dash, and packs the symbols of one letter into a code
//   register. When the inter-letter gap expires, the letter is presented on
//   code/len/err with a one-cycle valid strobe.
//
//   Optional build macro: MORSE_GLITCH_FILTER_EN
//     defined   - a press released before any tick was seen is discarded
//     undefined - such a press counts as a dot
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no letter in progress, waiting for the first press
//   PRESS | key held, counting press ticks
//   GAP   | key released inside a letter, counting gap ticks toward emit

module morse_symbol_collector #(
   parameter int DASH_MIN  = 2,
   parameter int GAP_TICKS = 3,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       key,
   output logic [4:0] code,
   output logic [2:0] len,
   output logic       err,
   output logic       valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRESS = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
   // The emit fires on the tick that would bring the gap counter to GAP_TICKS.
   localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;
   localparam logic [2:0]       MAX_SYMS   = 3'd5;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_press_cnt;
   logic [CNT_W-1:0] r_gap_cnt;
   logic [4:0]       r_sr;
   logic [2:0]       r_len;
   logic             r_err;
   logic [4:0]       r_code;
   logic [2:0]       r_len_out;
   logic             r_err_out;
   logic             r_valid;

   logic             w_sym;
   logic             w_glitch;

   assign w_sym = (r_press_cnt >= DASH_MIN_C);

`ifdef MORSE_GLITCH_FILTER_EN
   assign w_glitch = (r_press_cnt == '0);
`else
   assign w_glitch = 1'b0;
`endif

   assign code  = r_code;
   assign len   = r_len_out;
   assign err   = r_err_out;
   assign valid = r_valid;

   // Letter FSM: press/gap timing, symbol shift-in and the emit of a letter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_press_cnt <= '0;
         r_gap_cnt   <= '0;
         r_sr        <= '0;
         r_len       <= '0;
         r_err       <= 1'b0;
         r_code      <= '0;
         r_len_out   <= '0;
         r_err_out   <= 1'b0;
         r_valid     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (key) begin
                  r_state     <= S_PRESS;
                  r_press_cnt <= '0;
               end
            end

            S_PRESS: begin
               if (key) begin
                  if (tick && (r_press_cnt != CNT_MAX_C)) begin
                     r_press_cnt <= r_press_cnt + 1'b1;
                  end
               end else if (w_glitch) begin
                  // Tickless press: dropped without touching the letter.
                  r_gap_cnt <= '0;
                  r_state   <= (r_len == '0) ? S_IDLE : S_GAP;
               end else begin
                  if (r_len == MAX_SYMS) begin
                     r_err <= 1'b1;
                  end else begin
                     r_sr  <= {r_sr[3:0], w_sym};
                     r_len <= r_len + 3'd1;
                  end
                  r_gap_cnt <= '0;
                  r_state   <= S_GAP;
               end
            end

            S_GAP: begin
               if (key) begin
                  // A press on the expiring tick still resumes the letter.
                  r_state     <= S_PRESS;
                  r_press_cnt <= '0;
               end else if (tick) begin
                  if (r_gap_cnt == GAP_LAST_C) begin
                     r_code    <= r_sr;
                     r_len_out <= r_len;
                     r_err_out <= r_err;
                     r_valid   <= 1'b1;
                     r_sr      <= '0;
                     r_len     <= '0;
                     r_err     <= 1'b0;
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                     r_state   <= S_IDLE;
                  end else if (r_gap_cnt != CNT_MAX_C) begin
                     r_gap_cnt <= r_gap_cnt + 1'b1;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_symbol_collector.sv
// Bench for morse_symbol_collector: directed letters with hand-computed
// expected code/len/err pushed into a queue; a monitor pops on every valid.

module tb_morse_symbol_collector;

   localparam int GAP = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       key;
   logic [4:0] code;
   logic [2:0] len;
   logic       err;
   logic       valid;

   typedef struct packed {
      logic [4:0] code;
      logic [2:0] len;
      logic       err;
   } exp_t;

   exp_t q_exp[$];
   exp_t r_pop;
   int   n_checks = 0;
   int   n_pass   = 0;

   morse_symbol_collector #(
      .DASH_MIN (2),
      .GAP_TICKS(GAP),
      .CNT_W    (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .key  (key),
      .code (code),
      .len  (len),
      .err  (err),
      .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Monitor: every valid cycle must match the oldest expected letter.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (q_exp.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            r_pop = q_exp.pop_front();
            check("code", int'(code), int'(r_pop.code));
            check("len",  int'(len),  int'(r_pop.len));
            check("err",  int'(err),  int'(r_pop.err));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         repeat (3) cyc();
         tick = 1'b1;
         cyc();
         tick = 1'b0;
      end
   endtask

   task automatic press(input int n);
      key = 1'b1;
      cyc();
      ticks(n);
      key = 1'b0;
      cyc();
   endtask

   task automatic expect_letter(input logic [4:0] c, input logic [2:0] l, input logic e);
      exp_t x;
      x.code = c;
      x.len  = l;
      x.err  = e;
      q_exp.push_back(x);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (q_exp.size() == 0) break;
         cyc();
      end
      check(name, q_exp.size(), 0);
      q_exp.delete();
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      key   = 1'b0;
      repeat (3) cyc();
      check("rst_code",  int'(code),  0);
      check("rst_len",   int'(len),   0);
      check("rst_err",   int'(err),   0);
      check("rst_valid", int'(valid), 0);
      reset = 1'b0;
      cyc();

      // Letter A: dot, dash.
      expect_letter(5'b00001, 3'd2, 1'b0);
      press(1); ticks(1);
      press(3); ticks(GAP);
      drain("drain_A");

      // Six dots: sixth dropped, error flagged.
      expect_letter(5'b00000, 3'd5, 1'b1);
      for (int i = 0; i < 6; i++) begin
         press(1);
         ticks((i == 5) ? GAP : 1);
      end
      drain("drain_six");

      // Letter T: error flag must not carry over.
      expect_letter(5'b00001, 3'd1, 1'b0);
      press(3); ticks(GAP);
      drain("drain_T");

      // Gap boundary: key on the expiring tick resumes the letter (dash, dot).
      expect_letter(5'b00010, 3'd2, 1'b0);
      press(3);
      ticks(GAP - 1);
      repeat (3) cyc();
      key  = 1'b1;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      ticks(1);
      key = 1'b0;
      cyc();
      ticks(GAP);
      drain("drain_boundary");

      // Tickless one-cycle press between two dots.
`ifdef MORSE_GLITCH_FILTER_EN
      expect_letter(5'b00000, 3'd2, 1'b0);
`else
      expect_letter(5'b00000, 3'd3, 1'b0);
`endif
      press(1); ticks(1);
      key = 1'b1; cyc();
      key = 1'b0; cyc();
      ticks(1);
      press(1); ticks(GAP);
      drain("drain_glitch");

      // Reset mid-letter after two dots: outputs clear at once, no emit.
      press(1); ticks(1);
      press(1); ticks(1);
      cyc();
      #2 reset = 1'b1;
      #1;
      check("midrst_code",  int'(code),  0);
      check("midrst_len",   int'(len),   0);
      check("midrst_err",   int'(err),   0);
      check("midrst_valid", int'(valid), 0);
      cyc(); cyc();
      #3 reset = 1'b0;
      cyc();
      ticks(GAP + 2);
      drain("drain_reset");

      // Saturating press counter: long hold is a single dash.
      expect_letter(5'b00001, 3'd1, 1'b0);
      press(300); ticks(GAP);
      drain("drain_sat");

      repeat (3) cyc();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/morse_symbol_collector.md
# morse_symbol_collector

Collects dot/dash symbols from a debounced Morse key and assembles them into one letter code. It measures each key press in timebase ticks, classifies the press as dot or dash, and shifts it into a code register. When the inter-letter gap expires it emits a one-cycle `valid` with the code, symbol count and an overflow flag. It sits directly upstream of the ASCII lookup and the n-bit 2:1 display-select mux, which consume `code`/`len` and choose between the decoded character and a blank.

## Interface
- `DASH_MIN`, 2: press length in ticks at or above which a press is a dash; below it is a dot.
- `GAP_TICKS`, 3: released ticks that end a letter.
- `CNT_W`, 8: width of the press and gap counters, which saturate at 2^CNT_W-1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: timebase enable, one `clk` cycle wide; all durations are counted in ticks.
- `key` input 1: debounced key, synchronous to `clk`, 1 = pressed.
- `code` output 5: letter symbols, 1 = dash. The newest symbol is in bit 0 and the first symbol is in bit `len-1`. Bits at and above `len` are 0.
- `len` output 3: symbol count 1..5, valid while `valid` is high.
- `err` output 1: the letter had more than 5 symbols.
- `valid` output 1: one-cycle strobe that marks `code`/`len`/`err` as a new letter.

## Operation
- Reset state: state = IDLE, counters = 0, shift register = 0, length = 0, `code` = 0, `len` = 0, `err` = 0, `valid` = 0.
- FSM states are IDLE, PRESS and GAP.
- **IDLE:**
  - `key`=1 moves to PRESS and clears the press counter.
- **PRESS:**
  - `key`=1 with `tick` increments the press counter (saturating).
  - `key`=0 classifies the press from the held counter value: dash if the counter is ≥ `DASH_MIN`, otherwise dot.
  - On that release, the symbol shifts in (`sr <= {sr[3:0], sym}`) and the length increments.
  - If the length is already 5, the symbol is dropped, the length stays 5 and the internal error flag is set.
  - The release then moves to GAP and clears the gap counter.
- **GAP:**
  - `key`=1 moves to PRESS, clears the press counter and continues the same letter.
  - `key`=0 with `tick` increments the gap counter.
  - When the gap counter reaches `GAP_TICKS`, the block emits the letter and moves to IDLE.
- **Emit:**
  - `code`, `len` and `err` load from the internal registers and `valid` pulses.
  - The shift register, length and error flag then clear.
  - `code`/`len`/`err` hold their values until the next emit.
- **Simultaneous events:**
  - A `key` transition has priority over `tick`. A tick arriving in the same cycle as a transition is not counted in either state.
  - `key`=1 in the cycle the gap would expire resumes the letter; no emit occurs.
- **Reset mid-letter:** the partial letter is discarded and no `valid` is produced.

## Timing
- `valid` is registered. It is high for exactly one cycle, following the edge at which the gap counter reaches `GAP_TICKS`.
- `code`/`len`/`err` change only on that same edge and are stable while `valid` is high.
- Letter latency: from the last release to `valid` is `GAP_TICKS` ticks plus one `clk`.
- Classification and shift happen on the edge that samples `key`=0 in PRESS. The state is GAP in the next cycle.
- Minimum accepted press or gap is one `clk` cycle. Input rate is unconstrained.

## Configuration
- `MORSE_GLITCH_FILTER_EN`:
  - **Defined:** a press released with press counter = 0 (no tick seen) is discarded. No symbol is added and the length is unchanged. The block returns to IDLE if the length is 0, otherwise to GAP with the gap counter cleared.
  - **Undefined:** such a press is classified as a dot like any other short press.

## Test plan
- **Letter "A":** press 1 tick, release 1 tick, press 3 ticks, release 3 ticks → one `valid`, `code`=5'b00001, `len`=3'd2, `err`=0.
- **Six dots, then a 3-tick gap:** → `len`=5, `code`=5'b00000, `err`=1. On the following letter "T" (one 3-tick press), `err`=0, `code`=5'b00001, `len`=1.
- **Gap boundary:** release for 2 ticks, then `key`=1 in the same cycle as the third tick → no `valid`, and the symbols continue the same letter.
- **Reset mid-letter:** assert `reset` asynchronously after two dots → all outputs 0 immediately, no `valid` after release.
- **Glitch filter:** 1-cycle press with no tick between two dots.
  - With `MORSE_GLITCH_FILTER_EN`: `len`=2.
  - Without it: `len`=3, `code`=5'b00000.
- **Saturation:** hold `key` for 300 ticks with `CNT_W`=8 → counter holds 255, result is a dash, `code`=5'b00001, `len`=1.
